// File: rtl/hat_man_sprite_fetch.sv
// Hat-man sprite fetch stage: box test, sprite ROM addressing with animation
// frame and optional horizontal mirror, and a fixed 3-cycle pipeline that
// returns a palette index qualified by sprite_on and a delayed blank.
// Optional feature macro: HAT_MAN_MIRROR_EN (mirror on facing_left when defined).
module hat_man_sprite_fetch #(
  parameter int unsigned SPR_W     = 32,
  parameter int unsigned SPR_H     = 32,
  parameter int unsigned FRAMES    = 4,
  parameter int unsigned FRAME_DIV = 8,
  parameter int unsigned ROM_AW    = 12
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic                      vsync,
  input  logic [9:0]                SprX,
  input  logic [9:0]                SprY,
  input  logic                      moving,
  input  logic                      facing_left,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [3:0]                rom_data,
  output logic [3:0]                index,
  output logic                      sprite_on,
  output logic                      blank_out,
  output logic [$clog2(FRAMES)-1:0] anim_frame
);

  localparam int unsigned XW = $clog2(SPR_W);
  localparam int unsigned YW = $clog2(SPR_H);
  localparam int unsigned FW = $clog2(FRAMES);
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // 11-bit operands so SprX + SPR_W past column 1023 cannot wrap to low X.
  logic [10:0] dx, dy, sx, sy;
  logic [10:0] x_end, y_end;
  logic        hit;
  logic [XW-1:0] relx;
  logic [YW-1:0] rely;
  logic [XW-1:0] col;
  logic [ROM_AW-1:0] addr_next;

  logic          hit_d1, hit_d2;
  logic          blank_d1, blank_d2;
  logic          vsync_prev;
  logic          vsync_fall;
  logic [DW-1:0] divider;

  assign dx    = {1'b0, DrawX};
  assign dy    = {1'b0, DrawY};
  assign sx    = {1'b0, SprX};
  assign sy    = {1'b0, SprY};
  assign x_end = sx + 11'(SPR_W);
  assign y_end = sy + 11'(SPR_H);

  // Only the low bits of the offsets ever reach the address; they equal the
  // low bits of the full 11-bit differences.
  assign relx = DrawX[XW-1:0] - SprX[XW-1:0];
  assign rely = DrawY[YW-1:0] - SprY[YW-1:0];

  // Stage 0: box test, column select and address formation.
  always_comb begin
    hit = (dx >= sx) && (dx < x_end) && (dy >= sy) && (dy < y_end);
`ifdef HAT_MAN_MIRROR_EN
    col = facing_left ? (XW'(SPR_W - 1) - relx) : relx;
`else
    col = relx;
`endif
    addr_next = hit ? ROM_AW'({anim_frame, rely, col}) : '0;
  end

`ifndef HAT_MAN_MIRROR_EN
  // Port kept for a stable interface; not used without the mirror feature.
  logic unused_facing_left;
  assign unused_facing_left = facing_left;
`endif

  assign vsync_fall = vsync_prev & ~vsync;

  // Cycles 1-2: register the ROM address and carry hit/blank alongside the read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      hit_d2   <= 1'b0;
      blank_d1 <= 1'b0;
      blank_d2 <= 1'b0;
    end else begin
      rom_addr <= addr_next;
      hit_d1   <= hit;
      hit_d2   <= hit_d1;
      blank_d1 <= blank;
      blank_d2 <= blank_d1;
    end
  end

  // Cycle 3: qualify ROM data; index 0 is the transparent key colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      index     <= '0;
      sprite_on <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      blank_out <= blank_d2;
      if (hit_d2 && blank_d2 && (rom_data != 4'd0)) begin
        sprite_on <= 1'b1;
        index     <= rom_data;
      end else begin
        sprite_on <= 1'b0;
        index     <= '0;
      end
    end
  end

  // Animation: step once every FRAME_DIV vsync falling edges while moving.
  // Updates land only on the edge cycle, i.e. inside vertical blank.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vsync_prev <= 1'b1;
      divider    <= '0;
      anim_frame <= '0;
    end else begin
      vsync_prev <= vsync;
      if (vsync_fall) begin
        if (moving) begin
          if (divider == DW'(FRAME_DIV - 1)) begin
            divider    <= '0;
            anim_frame <= anim_frame + FW'(1);
          end else begin
            divider <= divider + DW'(1);
          end
        end else begin
          divider    <= '0;
          anim_frame <= '0;
        end
      end
    end
  end

endmodule

// File: doc/hat_man_sprite_fetch.md
Name: hat_man_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of the Hat-man 16-entry palette lookup.
- Per VGA pixel, tests whether (DrawX, DrawY) lies inside the Hat-man sprite box.
- Generates the sprite ROM address, including animation frame and optional horizontal mirror, and registers the returned 4-bit palette index.
- Emits the index with a sprite_on qualifier, aligned with a delayed blank, for the palette and colour mapper downstream.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2).
- SPR_H, 32, sprite height in pixels (power of 2).
- FRAMES, 4, animation frames stored back-to-back in ROM (power of 2).
- FRAME_DIV, 8, vsync periods per animation step (≥1).
- ROM_AW, 12, ROM address width = log2(SPR_W*SPR_H*FRAMES).

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  display-enable, 1 = visible
- vsync  in  1  active-low vertical sync
- SprX  in  10  sprite top-left column
- SprY  in  10  sprite top-left row
- moving  in  1  1 = animate, 0 = hold frame 0
- facing_left  in  1  mirror request
- rom_addr  out  ROM_AW  sprite ROM address (synchronous ROM, 1-cycle read)
- rom_data  in  4  ROM read data
- index  out  4  palette index to the palette lookup
- sprite_on  out  1  pixel is an opaque sprite pixel
- blank_out  out  1  blank delayed to match index
- anim_frame  out  log2(FRAMES)  current frame

Behaviour:
- Clock and reset: one clock Clk; synchronous active-high Reset. On Reset, all registers clear: rom_addr=0, index=0, sprite_on=0, blank_out=0, anim_frame=0, divider=0, vsync history=1, pipeline valid bits=0.
- Stage 0 (combinational):
  - relx = DrawX-SprX, rely = DrawY-SprY, both 11-bit.
  - hit = (DrawX≥SprX) && (DrawX<SprX+SPR_W) && (DrawY≥SprY) && (DrawY<SprY+SPR_H).
  - Sums use 11-bit arithmetic, so a sprite extending past column 1023 never wraps into a false hit at low X.
- Mirror: if enabled and facing_left=1, col = SPR_W-1-relx; otherwise col = relx.
- Address: anim_frame*SPR_W*SPR_H + rely*SPR_W + col, formed by concatenation {anim_frame, rely[log2 SPR_H-1:0], col[log2 SPR_W-1:0]}. When hit=0, the address is don't-care but rom_addr is held at 0.
- Cycle 1: rom_addr registered; hit and blank delayed into d1.
- Cycle 2: ROM drives rom_data; d1 moves to d2.
- Cycle 3: index, sprite_on and blank_out registered.
  - sprite_on = hit_d2 && blank_d2 && (rom_data≠0). Index 0 is the transparent key colour.
  - index = sprite_on ? rom_data : 0.
- Latency: fixed 3 Clk from DrawX/DrawY/blank to index/sprite_on/blank_out. No stalls; one pixel per clock.
- Animation:
  - Falling edge of vsync is detected from a registered previous value.
  - On each edge with moving=1: divider increments; when divider==FRAME_DIV-1 it wraps to 0 and anim_frame advances mod FRAMES (FRAMES-1 → 0).
  - On an edge with moving=0: divider=0, anim_frame=0.
  - anim_frame changes only on the edge cycle, i.e. during vertical blank, so a frame never tears mid-screen.
- Simultaneous events: Reset wins over a vsync edge. A vsync edge and a hit in the same cycle use the pre-update anim_frame for that pixel.
- Reset mid-line: pipeline contents are discarded; outputs are 0 for 3 cycles after Reset deasserts, then track the inputs.
- SprX/SprY/facing_left are sampled every cycle. The driver changes them only during vertical blank.

Optional Feature:
- Macro HAT_MAN_MIRROR_EN.
- Defined: facing_left selects the mirrored column as above.
- Undefined: facing_left is ignored (port kept for a stable interface) and col = relx always. Mirror logic is not synthesized.

Test Plan:
- Reset mid-pipeline: Reset for 2 cycles mid-line -> index=0, sprite_on=0, blank_out=0, anim_frame=0 until the 3rd cycle after release.
- Hit and address: SprX=100, SprY=50, anim_frame=0, DrawX=100, DrawY=50, blank=1 -> rom_addr=0 one cycle later. DrawX=131, DrawY=81 -> rom_addr=1023. ROM model returns 5 -> index=5, sprite_on=1 exactly 3 cycles after input.
- Bounds: DrawX=99 or 132 with same SprX -> sprite_on=0, index=0. Any opaque rom_data with blank=0 -> sprite_on=0. rom_data=0 inside the box -> sprite_on=0.
- Right-edge wrap: SprX=1010, DrawX=5 -> no hit. DrawX=1020 -> hit, relx=10.
- Animation: moving=1, FRAME_DIV=8 -> anim_frame steps 0→1 after the 8th vsync falling edge and 3→0 after the 32nd. moving=0 on the next edge -> anim_frame=0. At frame 2, pixel (0,0) -> rom_addr=2048.
- Mirror (HAT_MAN_MIRROR_EN defined): facing_left=1, relx=0 -> col=31, rom_addr=31. Macro undefined: same stimulus -> rom_addr=0.
